// File: rtl/spi_master_ctrl_if.sv
// Host and SPI bus signals of spi_master_ctrl, bundled for port connection.
//   start    host -> ctrl   request a frame (taken only while busy = 0)
//   tx_data  host -> ctrl   word to send, captured on the accepting cycle
//   busy     ctrl -> host   frame in progress
//   done     ctrl -> host   one-cycle pulse at frame end
//   rx_data  ctrl -> host   received word, valid from the done cycle
//   sclk/cs/mosi  ctrl -> SPI slave
//   miso          SPI slave -> ctrl
// Modport master is the requesting side (host plus SPI slave model);
// modport slave is the controller serving the requests.
interface spi_master_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  start;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  sclk;
   logic                  cs;
   logic                  mosi;
   logic                  miso;

   modport master (
      output start, tx_data, miso,
      input  busy, done, rx_data, sclk, cs, mosi
   );

   modport slave (
      input  start, tx_data, miso,
      output busy, done, rx_data, sclk, cs, mosi
   );
endinterface

// File: rtl/spi_master_ctrl.sv
// Single-clock SPI master: one full-duplex, MSB-first frame per accepted
// start. Frame = SETUP (CLK_DIV cycles, cs active), TRANSFER (2*DATA_WIDTH
// sclk half-periods of CLK_DIV cycles), HOLD (CLK_DIV cycles), then the done
// cycle back in IDLE. All outputs are registered.
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  spi_master_ctrl_if.slave: start/tx_data/busy/done/rx_data host
//        handshake plus sclk/cs/mosi/miso SPI pins
module spi_master_ctrl #(
   parameter bit          CPOL                        = 1'b0,
   parameter bit          CPHA                        = 1'b0,
   parameter bit          CHIP_SELECT_ACTIVE_POLARITY = 1'b0,
   parameter int unsigned DATA_WIDTH                  = 8,
   parameter int unsigned CLK_DIV                     = 2
) (
   input logic               clk,
   input logic               rst,
   spi_master_ctrl_if.slave  bus
);

   localparam int unsigned     HC_W    = $clog2(CLK_DIV) + 1;
   localparam int unsigned     EC_W    = $clog2(2 * DATA_WIDTH) + 1;
   localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);
   localparam logic [EC_W-1:0] EC_LAST = EC_W'(2 * DATA_WIDTH - 1);
   localparam logic            CS_ACT  = CHIP_SELECT_ACTIVE_POLARITY;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_TRANSFER,
      ST_HOLD
   } state_t;

   state_t                state_q, state_d;
   logic [HC_W-1:0]       hcnt_q, hcnt_d;
   logic [EC_W-1:0]       ecnt_q, ecnt_d;
   logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
   logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  sclk_q, sclk_d;
   logic                  cs_q, cs_d;
   logic                  mosi_q, mosi_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic half_end;
   logic leading;
   logic sample_edge;

   assign half_end    = (hcnt_q == HC_LAST);
   // ecnt_q counts edges already driven, so the edge about to be driven is
   // odd (leading) when ecnt_q is even.
   assign leading     = ~ecnt_q[0];
   assign sample_edge = (leading != CPHA);

   always_comb begin
      state_d   = state_q;
      hcnt_d    = hcnt_q;
      ecnt_d    = ecnt_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      rx_data_d = rx_data_q;
      sclk_d    = sclk_q;
      cs_d      = cs_q;
      mosi_d    = mosi_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            mosi_d = 1'b0;
            sclk_d = CPOL;
            if (bus.start) begin
               tx_sr_d = bus.tx_data;
               rx_sr_d = '0;
               hcnt_d  = '0;
               ecnt_d  = '0;
               cs_d    = CS_ACT;
               busy_d  = 1'b1;
               // CPHA=0 presents the MSB with cs; CPHA=1 waits for edge 1.
               mosi_d  = CPHA ? 1'b0 : bus.tx_data[DATA_WIDTH-1];
               state_d = ST_SETUP;
            end
         end

         ST_SETUP: begin
            if (half_end) begin
               hcnt_d  = '0;
               state_d = ST_TRANSFER;
            end else begin
               hcnt_d = hcnt_q + HC_W'(1);
            end
         end

         ST_TRANSFER: begin
            if (half_end) begin
               hcnt_d = '0;
               sclk_d = ~sclk_q;
               ecnt_d = ecnt_q + EC_W'(1);
               if (sample_edge) begin
                  // miso is stable across the half-period ending here.
                  rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], bus.miso};
               end else if (CPHA) begin
                  mosi_d  = tx_sr_q[DATA_WIDTH-1];
                  tx_sr_d = tx_sr_q << 1;
               end else if (ecnt_q != EC_LAST) begin
                  mosi_d  = tx_sr_q[DATA_WIDTH-2];
                  tx_sr_d = tx_sr_q << 1;
               end
               if (ecnt_q == EC_LAST) begin
                  ecnt_d  = '0;
                  state_d = ST_HOLD;
               end
            end else begin
               hcnt_d = hcnt_q + HC_W'(1);
            end
         end

         ST_HOLD: begin
            if (half_end) begin
               hcnt_d    = '0;
               cs_d      = ~CS_ACT;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               rx_data_d = rx_sr_q;
               mosi_d    = 1'b0;
               state_d   = ST_IDLE;
            end else begin
               hcnt_d = hcnt_q + HC_W'(1);
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         hcnt_q    <= '0;
         ecnt_q    <= '0;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         rx_data_q <= '0;
         sclk_q    <= CPOL;
         cs_q      <= ~CS_ACT;
         mosi_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hcnt_q    <= hcnt_d;
         ecnt_q    <= ecnt_d;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         rx_data_q <= rx_data_d;
         sclk_q    <= sclk_d;
         cs_q      <= cs_d;
         mosi_q    <= mosi_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rx_data = rx_data_q;
   assign bus.sclk    = sclk_q;
   assign bus.cs      = cs_q;
   assign bus.mosi    = mosi_q;

endmodule
